wb_port_arbiter: RTL and testbench

Arbiter for the single register-file write port, shared between the in-order pipeline's MEM/WB writeback and a multi-cycle multiplier's out-of-band results. Pipeline writebacks always win. Multiplier results wait in a small FIFO and drain into idle writeback slots. A pending-register mask feeds the issue interlock, and a starvation stall forces a bubble when the FIFO cannot drain.

---
 rtl/wb_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : wb_port_arbiter
// Desc    : Shares the single register-file write port between the MEM/WB
//           writeback and out-of-band multiplier results. Pipeline writes
//           always win. Multiplier results wait in a small FIFO and drain into
//           idle writeback slots. A pending-register mask feeds the issue
//           interlock. A starvation stall requests a front-end bubble when
//           the FIFO cannot drain.
// Options : WB_BYPASS_EN - when defined, an accepted result that finds the FIFO
//           empty and the pipe slot idle is written straight to the port.
// Rev     : 1.0 - initial release
//==============================================================================
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [5:0]  pipe_reg_num_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mul_valid_i,
  input  logic [4:0]  mul_rd_i,
  input  logic [31:0] mul_data_i,
  output logic        mul_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pend_o,
  output logic        stall_o
);

  localparam int                 c_PTR_W      = $clog2(DEPTH);
  localparam int                 c_CNT_W      = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);
  localparam logic [4:0]         c_STARVE_MAX = 5'(STARVE_MAX);
  localparam logic [4:0]         c_STARVE_SAT = 5'd31;

  // FIFO storage: one live flag, destination and data per slot
  logic [DEPTH-1:0]   r_live;
  logic [4:0]         r_rd   [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic [4:0]         r_starve;
  logic               r_stall;
  logic               r_rf_we;
  logic [4:0]         r_rf_waddr;
  logic [31:0]        r_rf_wdata;

  logic               w_busy;
  logic [4:0]         w_pipe_rd;
  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_bypass;
  logic               w_push;
  logic               w_push_live;
  logic               w_head_live;
  logic               w_pop;
  logic               w_live_pop;
  logic               w_any_live;
  logic [DEPTH-1:0]   w_squash;
  logic [DEPTH-1:0]   w_live_nxt;
  logic [31:0]        w_pend;
  logic [4:0]         w_starve_nxt;
  logic               w_stall_nxt;

  assign w_busy      = pipe_reg_num_i[5];
  assign w_pipe_rd   = pipe_reg_num_i[4:0];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_DEPTH);
  // Held low during reset so nothing can be handed over while state is cleared
  assign mul_ready_o = rst_n_i & ~w_full;
  assign w_accept    = mul_valid_i & mul_ready_o;

`ifdef WB_BYPASS_EN
  // Nothing queued ahead and the port is free: skip the FIFO entirely
  assign w_bypass = w_accept & w_empty & ~w_busy;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_accept & ~w_bypass;
  // A same-cycle pipe write to the same register is younger and wins
  assign w_push_live = ~(w_busy & (mul_rd_i == w_pipe_rd));

  assign w_head_live = ~w_empty & r_live[r_head];
  // Dead heads are discarded even when the pipe owns the port
  assign w_pop       = ~w_empty & (~w_busy | ~r_live[r_head]);
  assign w_live_pop  = w_pop & w_head_live;
  assign w_any_live  = |r_live;

  // Per-slot match against the pipe write that supersedes queued results
  for (genvar g = 0; g < DEPTH; g++) begin : g_squash
    assign w_squash[g] = w_busy & (r_rd[g] == w_pipe_rd);
  end

  // Next live flags: squash, retire the popped head, mark the new tail
  always_comb begin
    w_live_nxt = r_live & ~w_squash;
    if (w_pop) begin
      w_live_nxt[r_head] = 1'b0;
    end
    if (w_push) begin
      w_live_nxt[r_tail] = w_push_live;
    end
  end

  // Pending mask: one bit per register with a live queued result
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) begin
        w_pend[r_rd[i]] = 1'b1;
      end
    end
  end

  assign pend_o = w_pend;

  // Starvation tracking; a stall with nothing live left to drain would never
  // see a live pop, so it also drops once the queue holds no live entry
  always_comb begin
    w_starve_nxt = r_starve;
    w_stall_nxt  = r_stall;
    if (w_live_pop || !w_any_live) begin
      w_starve_nxt = '0;
      w_stall_nxt  = 1'b0;
    end else if (w_head_live && w_busy) begin
      if (r_starve != c_STARVE_SAT) begin
        w_starve_nxt = r_starve + 5'd1;
      end
      if (w_starve_nxt == c_STARVE_MAX) begin
        w_stall_nxt = 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_live <= w_live_nxt;
      if (w_push) begin
        r_rd[r_tail]   <= mul_rd_i;
        r_data[r_tail] <= mul_data_i;
        r_tail         <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter and front-end bubble request
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= w_stall_nxt;
    end
  end

  // Write-port register: pipe first, then live FIFO head, then bypass
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_busy) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_pipe_rd;
      r_rf_wdata <= pipe_data_i;
    end else if (w_live_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_rd[r_head];
      r_rf_wdata <= r_data[r_head];
    end else if (w_bypass) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= mul_rd_i;
      r_rf_wdata <= mul_data_i;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we_o    = r_rf_we;
  assign rf_waddr_o = r_rf_waddr;
  assign rf_wdata_o = r_rf_wdata;
  assign stall_o    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_wb_port_arbiter
// Desc    : Directed self-checking bench for wb_port_arbiter
// Rev     : 1.0 - initial release
//==============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk_i;
  logic        rst_n_i;
  logic [5:0]  pipe_reg_num_i;
  logic [31:0] pipe_data_i;
  logic        mul_valid_i;
  logic [4:0]  mul_rd_i;
  logic [31:0] mul_data_i;
  logic        mul_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] pend_o;
  logic        stall_o;

  int n_cmp;
  int n_err;

  wb_port_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .pipe_reg_num_i (pipe_reg_num_i),
    .pipe_data_i    (pipe_data_i),
    .mul_valid_i    (mul_valid_i),
    .mul_rd_i       (mul_rd_i),
    .mul_data_i     (mul_data_i),
    .mul_ready_o    (mul_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pend_o         (pend_o),
    .stall_o        (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pipe(input logic busy, input logic [4:0] rd, input logic [31:0] d);
    pipe_reg_num_i = busy ? {1'b1, rd} : 6'b011111;
    pipe_data_i    = d;
  endtask

  task automatic set_mul(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mul_valid_i = v;
    mul_rd_i    = rd;
    mul_data_i  = d;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp += 6;
    if (rf_we_o !== 1'b0)     begin n_err++; $display("FAIL por_we: got %0h want 0", rf_we_o); end
    if (rf_waddr_o !== 5'd0)  begin n_err++; $display("FAIL por_waddr: got %0h want 0", rf_waddr_o); end
    if (rf_wdata_o !== 32'd0) begin n_err++; $display("FAIL por_wdata: got %0h want 0", rf_wdata_o); end
    if (stall_o !== 1'b0)     begin n_err++; $display("FAIL por_stall: got %0h want 0", stall_o); end
    if (pend_o !== 32'd0)     begin n_err++; $display("FAIL por_pend: got %0h want 0", pend_o); end
    if (mul_ready_o !== 1'b0) begin n_err++; $display("FAIL por_ready: got %0h want 0", mul_ready_o); end
    rst_n_i = 1'b1;
    // queue r1, r2, r4 while the pipe keeps the port busy
    set_pipe(1'b1, 5'd3, 32'h77);
    set_mul(1'b1, 5'd1, 32'hA1);
    tick();
    set_mul(1'b1, 5'd2, 32'hA2);
    tick();
    set_mul(1'b1, 5'd4, 32'hA4);
    tick();
    set_mul(1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (pend_o !== 32'h16) begin n_err++; $display("FAIL pre_rst_pend: got %0h want 16", pend_o); end
    rst_n_i = 1'b0;
    #1;
    n_cmp += 6;
    if (rf_we_o !== 1'b0)     begin n_err++; $display("FAIL rst_we: got %0h want 0", rf_we_o); end
    if (rf_waddr_o !== 5'd0)  begin n_err++; $display("FAIL rst_waddr: got %0h want 0", rf_waddr_o); end
    if (rf_wdata_o !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %0h want 0", rf_wdata_o); end
    if (stall_o !== 1'b0)     begin n_err++; $display("FAIL rst_stall: got %0h want 0", stall_o); end
    if (pend_o !== 32'd0)     begin n_err++; $display("FAIL rst_pend: got %0h want 0", pend_o); end
    if (mul_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0h want 0", mul_ready_o); end
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    rst_n_i = 1'b1;
    #1;
    n_cmp += 2;
    if (mul_ready_o !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %0h want 1", mul_ready_o); end
    if (pend_o !== 32'd0)     begin n_err++; $display("FAIL rel_pend: got %0h want 0", pend_o); end
    tick();
    // queued results were discarded: an idle slot must not drain anything
    n_cmp++;
    if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL rel_no_drain: got %0h want 0", rf_we_o); end
  endtask

  task automatic test_pipe_priority();
    set_pipe(1'b1, 5'd3, 32'h11);
    set_mul(1'b1, 5'd7, 32'hAA);
    tick();
    set_mul(1'b0, 5'd0, 32'h0);
    n_cmp += 3;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h11) begin
      n_err++; $display("FAIL prio_first: got we=%0h a=%0h d=%0h want 1/3/11", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    if (pend_o !== 32'h80) begin n_err++; $display("FAIL prio_pend: got %0h want 80", pend_o); end
    if (stall_o !== 1'b0)  begin n_err++; $display("FAIL prio_stall0: got %0h want 0", stall_o); end
    for (int i = 1; i <= STARVE_MAX; i++) begin
      tick();
      n_cmp += 2;
      if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h11) begin
        n_err++; $display("FAIL prio_pipe_only[%0d]: got a=%0h d=%0h want 3/11", i, rf_waddr_o, rf_wdata_o);
      end
      if (stall_o !== (i == STARVE_MAX)) begin
        n_err++; $display("FAIL prio_stall[%0d]: got %0h want %0h", i, stall_o, (i == STARVE_MAX));
      end
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    n_cmp += 3;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'hAA) begin
      n_err++; $display("FAIL prio_drain: got we=%0h a=%0h d=%0h want 1/7/aa", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL prio_pend_clr: got %0h want 0", pend_o); end
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL prio_stall_clr: got %0h want 0", stall_o); end
  endtask

  task automatic test_full_fifo();
    set_pipe(1'b1, 5'd0, 32'hB0);
    for (int k = 1; k <= 4; k++) begin
      set_mul(1'b1, 5'(k), 32'h100 + k);
      tick();
    end
    n_cmp++;
    if (mul_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0h want 0", mul_ready_o); end
    set_mul(1'b1, 5'd5, 32'h105);
    tick();
    n_cmp += 2;
    if (mul_ready_o !== 1'b0) begin n_err++; $display("FAIL full_hold: got %0h want 0", mul_ready_o); end
    if (pend_o !== 32'h1E)    begin n_err++; $display("FAIL full_pend: got %0h want 1e", pend_o); end
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    n_cmp += 2;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h101) begin
      n_err++; $display("FAIL full_order[1]: got we=%0h a=%0h d=%0h want 1/1/101", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    if (mul_ready_o !== 1'b1) begin n_err++; $display("FAIL full_reopen: got %0h want 1", mul_ready_o); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 2) set_mul(1'b0, 5'd0, 32'h0);
      n_cmp++;
      if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'(k) || rf_wdata_o !== 32'h100 + k) begin
        n_err++; $display("FAIL full_order[%0d]: got we=%0h a=%0h d=%0h", k, rf_we_o, rf_waddr_o, rf_wdata_o);
      end
    end
    tick();
    n_cmp += 2;
    if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL full_idle: got %0h want 0", rf_we_o); end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL full_pend_end: got %0h want 0", pend_o); end
  endtask

  task automatic test_squash();
    // queued entry later superseded by the pipe
    set_pipe(1'b1, 5'd6, 32'h66);
    set_mul(1'b1, 5'd5, 32'h1234);
    tick();
    set_mul(1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (pend_o !== 32'h20) begin n_err++; $display("FAIL sq_pend_set: got %0h want 20", pend_o); end
    set_pipe(1'b1, 5'd5, 32'h9);
    tick();
    n_cmp += 2;
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL sq_pend_clr: got %0h want 0", pend_o); end
    if (rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h9) begin
      n_err++; $display("FAIL sq_pipe_wr: got a=%0h d=%0h want 5/9", rf_waddr_o, rf_wdata_o);
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL sq_no_write[%0d]: got %0h want 0", i, rf_we_o); end
    end
    // push and pipe write to the same register on the same edge
    set_pipe(1'b1, 5'd5, 32'h9);
    set_mul(1'b1, 5'd5, 32'h1234);
    tick();
    set_mul(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 32'h0);
    n_cmp += 2;
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL sq_same_pend: got %0h want 0", pend_o); end
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h9) begin
      n_err++; $display("FAIL sq_same_pipe: got we=%0h a=%0h d=%0h want 1/5/9", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL sq_same_no_write[%0d]: got %0h want 0", i, rf_we_o); end
    end
  endtask

  task automatic test_bypass();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mul(1'b1, 5'd9, 32'h55);
    tick();
    set_mul(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    n_cmp += 2;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'h55) begin
      n_err++; $display("FAIL byp_write: got we=%0h a=%0h d=%0h want 1/9/55", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL byp_pend: got %0h want 0", pend_o); end
    tick();
    n_cmp += 2;
    if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL byp_after: got %0h want 0", rf_we_o); end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL byp_pend2: got %0h want 0", pend_o); end
`else
    n_cmp += 2;
    if (rf_we_o !== 1'b0)   begin n_err++; $display("FAIL nobyp_early: got %0h want 0", rf_we_o); end
    if (pend_o !== 32'h200) begin n_err++; $display("FAIL nobyp_pend: got %0h want 200", pend_o); end
    tick();
    n_cmp += 2;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'h55) begin
      n_err++; $display("FAIL nobyp_write: got we=%0h a=%0h d=%0h want 1/9/55", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL nobyp_pend_clr: got %0h want 0", pend_o); end
`endif
  endtask

  task automatic test_wrap();
    logic [36:0] q[$];
    logic [36:0] e;
    int          sent;
    int          got;
    logic        busy;
    logic        acc;
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic        byp;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (sent == 3 * DEPTH && q.size() == 0) break;
      busy = (cyc % 2) == 1;
      set_pipe(busy, 5'd0, 32'hF000 + cyc);
      set_mul(sent < 3 * DEPTH, 5'(sent + 1), 32'hC0DE0000 + sent);
      n_cmp++;
      if (mul_ready_o !== (q.size() < DEPTH)) begin
        n_err++; $display("FAIL wrap_ready[%0d]: got %0h want %0h", cyc, mul_ready_o, (q.size() < DEPTH));
      end
      acc = mul_valid_i && (q.size() < DEPTH);
      byp = 1'b0;
      exp_we = 1'b1;
      exp_a  = 5'd0;
      exp_d  = 32'hF000 + cyc;
      if (!busy && q.size() > 0) begin
        e = q.pop_front();
        exp_a = e[36:32];
        exp_d = e[31:0];
        got++;
      end else if (!busy) begin
`ifdef WB_BYPASS_EN
        if (acc) begin
          byp   = 1'b1;
          exp_a = mul_rd_i;
          exp_d = mul_data_i;
          got++;
        end else begin
          exp_we = 1'b0;
        end
`else
        exp_we = 1'b0;
`endif
      end
      if (acc && !byp) q.push_back({mul_rd_i, mul_data_i});
      if (acc) sent++;
      tick();
      n_cmp++;
      if (rf_we_o !== exp_we || (exp_we && (rf_waddr_o !== exp_a || rf_wdata_o !== exp_d))) begin
        n_err++;
        $display("FAIL wrap_write[%0d]: got we=%0h a=%0h d=%0h want we=%0h a=%0h d=%0h",
                 cyc, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_a, exp_d);
      end
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mul(1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (sent != 3 * DEPTH || got != 3 * DEPTH || q.size() != 0) begin
      n_err++; $display("FAIL wrap_timeout: got sent=%0d written=%0d want %0d", sent, got, 3 * DEPTH);
    end
    tick();
    n_cmp += 2;
    if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL wrap_extra_write: got %0h want 0", rf_we_o); end
    if (pend_o !== 32'h0) begin n_err++; $display("FAIL wrap_pend_end: got %0h want 0", pend_o); end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n_i = 1'b0;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mul(1'b0, 5'd0, 32'h0);
    test_reset();
    test_pipe_priority();
    test_full_fifo();
    test_squash();
    test_bypass();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
